// File: rtl/cc_mux_scan.sv
// Registered N:1 channel selector: manual select with clamp, or round-robin
// scan over an enabled channel mask with programmable dwell.
//   state     | meaning
//   ST_MANUAL | follow external select, clamped to the last channel
//   ST_SCAN   | rotate over enabled channels, dwell+1 cycles each
//   ST_NOCHAN | scan requested but mask empty; outputs frozen, valid low
module cc_mux_scan #(
  parameter int NUMBER_DATAWIDTH   = 8,
  parameter int NUMBER_CHANNELS    = 10,
  parameter int NUMBER_SELECTWIDTH = 4,
  parameter int NUMBER_DWELLWIDTH  = 8
) (
  input  logic                                        CC_MUXSCAN_CLOCK_50,
  input  logic                                        CC_MUXSCAN_RESET_InLow,
  input  logic [NUMBER_CHANNELS*NUMBER_DATAWIDTH-1:0] CC_MUXSCAN_data_InBUS,
  input  logic [NUMBER_SELECTWIDTH-1:0]               CC_MUXSCAN_select_InBUS,
  input  logic                                        CC_MUXSCAN_mode_In,
  input  logic [NUMBER_CHANNELS-1:0]                  CC_MUXSCAN_enable_InBUS,
  input  logic [NUMBER_DWELLWIDTH-1:0]                CC_MUXSCAN_dwell_InBUS,
  input  logic                                        CC_MUXSCAN_hold_In,
  output logic [NUMBER_DATAWIDTH-1:0]                 CC_MUXSCAN_z_OutBUS,
  output logic [NUMBER_SELECTWIDTH-1:0]               CC_MUXSCAN_channel_OutBUS,
  output logic                                        CC_MUXSCAN_valid_Out,
  output logic                                        CC_MUXSCAN_switch_Out
);

  localparam int DW = NUMBER_DATAWIDTH;
  localparam int SW = NUMBER_SELECTWIDTH;
  localparam int CW = NUMBER_DWELLWIDTH;
  localparam logic [SW:0]   N_EXT   = (NUMBER_SELECTWIDTH + 1)'(NUMBER_CHANNELS);
  localparam logic [SW-1:0] LAST_CH = NUMBER_SELECTWIDTH'(NUMBER_CHANNELS - 1);

  typedef enum logic [1:0] {ST_MANUAL, ST_SCAN, ST_NOCHAN} state_t;

  state_t        state_q, state_d;
  logic [SW-1:0] channel_q, channel_d;
  logic [DW-1:0] z_q, z_d;
  logic [CW-1:0] count_q, count_d;
  logic          valid_q, valid_d;
  logic          switch_q, switch_d;

  logic [DW-1:0] chan_w [NUMBER_CHANNELS];
  logic [SW-1:0] next_en;
  logic [SW-1:0] sel_clamp;
  logic          found;
  logic [SW:0]   sum;

  for (genvar k = 0; k < NUMBER_CHANNELS; k++) begin : g_chan
    assign chan_w[k] = CC_MUXSCAN_data_InBUS[k*DW +: DW];
  end

  assign sel_clamp = ({1'b0, CC_MUXSCAN_select_InBUS} < N_EXT) ? CC_MUXSCAN_select_InBUS : LAST_CH;

  // Cyclic search from channel+1; the current channel is tried last, so a
  // lone enabled channel selects itself.
  always_comb begin
    next_en = channel_q;
    found   = 1'b0;
    sum     = '0;
    for (int i = 1; i <= NUMBER_CHANNELS; i++) begin
      sum = {1'b0, channel_q} + (NUMBER_SELECTWIDTH + 1)'(i);
      if (sum >= N_EXT) sum = sum - N_EXT;
      if (!found && CC_MUXSCAN_enable_InBUS[sum[SW-1:0]]) begin
        found   = 1'b1;
        next_en = sum[SW-1:0];
      end
    end
  end

  always_comb begin
    state_d   = ST_MANUAL;
    channel_d = channel_q;
    count_d   = count_q;
    valid_d   = 1'b1;
    if (CC_MUXSCAN_mode_In) state_d = (|CC_MUXSCAN_enable_InBUS) ? ST_SCAN : ST_NOCHAN;

    case (state_d)
      ST_MANUAL: begin
        channel_d = sel_clamp;
        count_d   = '0;
      end
      ST_NOCHAN: begin
        valid_d = 1'b0;
        count_d = '0;
      end
      default: begin
        if (state_q == ST_MANUAL) begin
          count_d = '0;
          if (!CC_MUXSCAN_enable_InBUS[channel_q]) channel_d = next_en;
        end else if (state_q == ST_NOCHAN) begin
          count_d   = '0;
          channel_d = next_en;
        end else if (!CC_MUXSCAN_enable_InBUS[channel_q]) begin
          // A disabled channel is left immediately, even while held.
          count_d   = '0;
          channel_d = next_en;
        end else if (!CC_MUXSCAN_hold_In) begin
          if (count_q == CC_MUXSCAN_dwell_InBUS) begin
            count_d   = '0;
            channel_d = next_en;
          end else begin
            count_d = count_q + 1'b1;
          end
        end
      end
    endcase

    z_d      = (state_d == ST_NOCHAN) ? z_q : chan_w[channel_d];
    switch_d = (channel_d != channel_q);
  end

  always_ff @(posedge CC_MUXSCAN_CLOCK_50 or negedge CC_MUXSCAN_RESET_InLow) begin
    if (!CC_MUXSCAN_RESET_InLow) begin
      state_q   <= ST_MANUAL;
      channel_q <= '0;
      z_q       <= '0;
      count_q   <= '0;
      valid_q   <= 1'b0;
      switch_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      channel_q <= channel_d;
      z_q       <= z_d;
      count_q   <= count_d;
      valid_q   <= valid_d;
      switch_q  <= switch_d;
    end
  end

  assign CC_MUXSCAN_z_OutBUS       = z_q;
  assign CC_MUXSCAN_channel_OutBUS = channel_q;
  assign CC_MUXSCAN_valid_Out      = valid_q;
  assign CC_MUXSCAN_switch_Out     = switch_q;

endmodule

// File: tb/tb_cc_mux_scan.sv
// Scoreboard bench for cc_mux_scan: directed plan checks plus randomized
// traffic compared against a rule-level reference model.
module tb_cc_mux_scan;
  localparam int DW = 8;
  localparam int N  = 10;
  localparam int SW = 4;
  localparam int WW = 8;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [N*DW-1:0] data = '0;
  logic [SW-1:0]   sel = '0;
  logic            mode = 1'b0;
  logic [N-1:0]    mask = '0;
  logic [WW-1:0]   dwell = '0;
  logic            hold = 1'b0;
  logic [DW-1:0]   z_o;
  logic [SW-1:0]   ch_o;
  logic            valid_o;
  logic            sw_o;

  cc_mux_scan #(
    .NUMBER_DATAWIDTH(DW), .NUMBER_CHANNELS(N),
    .NUMBER_SELECTWIDTH(SW), .NUMBER_DWELLWIDTH(WW)
  ) dut (
    .CC_MUXSCAN_CLOCK_50      (clk),
    .CC_MUXSCAN_RESET_InLow   (rst_n),
    .CC_MUXSCAN_data_InBUS    (data),
    .CC_MUXSCAN_select_InBUS  (sel),
    .CC_MUXSCAN_mode_In       (mode),
    .CC_MUXSCAN_enable_InBUS  (mask),
    .CC_MUXSCAN_dwell_InBUS   (dwell),
    .CC_MUXSCAN_hold_In       (hold),
    .CC_MUXSCAN_z_OutBUS      (z_o),
    .CC_MUXSCAN_channel_OutBUS(ch_o),
    .CC_MUXSCAN_valid_Out     (valid_o),
    .CC_MUXSCAN_switch_Out    (sw_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] z;
    int            ch;
    bit            v;
    bit            sw;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference model: what is on display, and how long it has been shown.
  int            m_ch = 0;
  int            m_shown = 0;
  bit            m_valid = 0;
  logic [DW-1:0] m_z = '0;
  bit            m_was_scan = 0;
  bit            m_was_empty = 0;

  function automatic logic [DW-1:0] chan(int k);
    return data[k*DW +: DW];
  endfunction

  function automatic bit enabled(int k);
    logic [N-1:0] m;
    m = mask >> k;
    return m[0];
  endfunction

  function automatic int next_enabled(int from);
    for (int k = 1; k <= N; k++)
      if (enabled((from + k) % N)) return (from + k) % N;
    return from;
  endfunction

  task automatic model_edge();
    exp_t e;
    int   nch;
    nch = m_ch;
    if (!rst_n) begin
      m_ch = 0; m_shown = 0; m_valid = 0; m_z = '0;
      m_was_scan = 0; m_was_empty = 0;
      e.z = '0; e.ch = 0; e.v = 0; e.sw = 0;
      exp_q.push_back(e);
      return;
    end
    if (!mode) begin
      nch = (int'(sel) < N) ? int'(sel) : N - 1;
      m_shown = 0; m_valid = 1; m_z = chan(nch);
      m_was_scan = 0; m_was_empty = 0;
    end else if (mask == '0) begin
      m_shown = 0; m_valid = 0;
      m_was_scan = 0; m_was_empty = 1;
    end else begin
      if (m_was_empty) begin
        nch = next_enabled(m_ch); m_shown = 0;
      end else if (!m_was_scan) begin
        m_shown = 0;
        if (!enabled(m_ch)) nch = next_enabled(m_ch);
      end else if (!enabled(m_ch)) begin
        nch = next_enabled(m_ch); m_shown = 0;
      end else if (!hold) begin
        // Channel leaves once it has already been shown dwell extra cycles.
        if (m_shown == int'(dwell)) begin
          nch = next_enabled(m_ch); m_shown = 0;
        end else begin
          m_shown = (m_shown + 1) % (1 << WW);
        end
      end
      m_valid = 1; m_z = chan(nch);
      m_was_scan = 1; m_was_empty = 0;
    end
    e.z = m_z; e.ch = nch; e.v = m_valid; e.sw = (nch != m_ch);
    exp_q.push_back(e);
    m_ch = nch;
  endtask

  task automatic cyc();
    model_edge();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(string name, int got, int want);
    n_checks++;
    if (got != want) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d, want %0d", name, $time, got, want);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_checks++;
        if (z_o !== e.z || int'(ch_o) != e.ch || valid_o !== e.v || sw_o !== e.sw) begin
          n_fail++;
          $display("FAIL scoreboard at %0t: got z=%h ch=%0d valid=%b sw=%b, want z=%h ch=%0d valid=%b sw=%b",
                   $time, z_o, ch_o, valid_o, sw_o, e.z, e.ch, e.v, e.sw);
        end
      end
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_reset_zero(string name);
    chk({name, "_z"}, int'(z_o), 0);
    chk({name, "_ch"}, int'(ch_o), 0);
    chk({name, "_valid"}, int'(valid_o), 0);
    chk({name, "_sw"}, int'(sw_o), 0);
  endtask

  initial begin : stim
    int rot_exp[15];
    rot_exp = '{0, 0, 0, 2, 2, 2, 5, 5, 5, 9, 9, 9, 0, 0, 0};
    for (int k = 0; k < N; k++) data[k*DW +: DW] = 8'(k * 17 + 3);

    // Reset and first update.
    sel = 4'd3;
    cyc();
    check_reset_zero("reset");
    rst_n = 1'b1;
    cyc();
    chk("release_ch", int'(ch_o), 3);
    chk("release_z", int'(z_o), int'(chan(3)));
    chk("release_valid", int'(valid_o), 1);
    chk("release_sw", int'(sw_o), 1);

    // Manual select sweep with clamping.
    for (int s = 0; s < 16; s++) begin
      sel = 4'(s);
      cyc();
      chk("clamp_ch", int'(ch_o), (s < N) ? s : N - 1);
      chk("clamp_sw", int'(sw_o), (s == 0 || (s > 0 && s < N)) ? 1 : 0);
    end
    chk("clamp_z", int'(z_o), int'(chan(9)));

    // Scan rotation from a fresh reset.
    rst_n = 1'b0;
    #1;
    check_reset_zero("reset2");
    cyc();
    rst_n = 1'b1;
    sel = '0; mode = 1'b1; mask = 10'b1000100101; dwell = 8'd2; hold = 1'b0;
    for (int i = 0; i < 15; i++) begin
      cyc();
      chk("rot_ch", int'(ch_o), rot_exp[i]);
      chk("rot_sw", int'(sw_o), (i > 0 && rot_exp[i] != rot_exp[i-1]) ? 1 : 0);
    end

    // Hold mid-dwell, then resume with remaining count.
    cyc(); cyc();
    chk("pre_hold_ch", int'(ch_o), 2);
    hold = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk("hold_ch", int'(ch_o), 2);
    end
    hold = 1'b0;
    cyc();
    chk("resume_ch", int'(ch_o), 2);
    cyc();
    chk("resume_adv_ch", int'(ch_o), 5);

    // Disable the current channel.
    mask = 10'b1000000101;
    cyc();
    chk("disable_ch", int'(ch_o), 9);
    chk("disable_sw", int'(sw_o), 1);

    // Empty mask, then one channel enabled.
    mask = '0;
    cyc(); cyc();
    chk("empty_valid", int'(valid_o), 0);
    chk("empty_ch", int'(ch_o), 9);
    chk("empty_z", int'(z_o), int'(chan(9)));
    mask = 10'b0010000000;
    cyc();
    chk("refill_ch", int'(ch_o), 7);
    chk("refill_valid", int'(valid_o), 1);
    chk("refill_sw", int'(sw_o), 1);

    // Back to manual.
    mode = 1'b0; sel = 4'd4;
    cyc();
    chk("to_manual_ch", int'(ch_o), 4);

    // Reset mid-dwell clears outputs without waiting for a clock.
    mode = 1'b1; mask = '1; dwell = 8'd5;
    cyc(); cyc(); cyc();
    chk("mid_dwell_ch", int'(ch_o), 4);
    rst_n = 1'b0;
    #1;
    check_reset_zero("async_reset");
    cyc();
    rst_n = 1'b1;

    // Randomized traffic.
    dwell = 8'd1;
    for (int c = 0; c < 3000; c++) begin
      for (int k = 0; k < N; k++) data[k*DW +: DW] = 8'($urandom);
      if ($urandom_range(0, 7) == 0) sel = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 39) == 0) mode = ~mode;
      if ($urandom_range(0, 29) == 0)
        mask = ($urandom_range(0, 3) == 0) ? '0 : 10'($urandom);
      if ($urandom_range(0, 59) == 0) dwell = 8'($urandom_range(0, 4));
      hold = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 499) == 0) begin
        rst_n = 1'b0;
        #1;
        check_reset_zero("rand_reset");
        cyc();
        rst_n = 1'b1;
      end else begin
        cyc();
      end
    end

    #20;
    chk("queue_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
